// File: rtl/pio_pkg.sv
// Shared constants for the debounced input PIO.
// Register offsets, edge encodings and counter width.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE    = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int DEBOUNCE_CNT_W = 24;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: synchroniser chain, persistence counter
// and the accepted (stable) level.
module pio_debounce_bit
  import pio_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic stable
);

  localparam logic [DEBOUNCE_CNT_W-1:0] LAST =
    DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0]    sync_q;
  logic [DEBOUNCE_CNT_W-1:0] cnt;
  logic                      sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      cnt    <= '0;
      stable <= RESET_LEVEL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
      // any return to the accepted level restarts the count
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pio_in_debounce_irq.sv
// Avalon-MM input PIO with per-bit debounce, edge capture,
// interrupt mask and a level interrupt.
module pio_in_debounce_irq
  import pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL[i])
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .in_bit  (in_port[i]),
      .stable  (stable[i])
    );
  end

  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISE: edge_det = stable & ~stable_d;
      EDGE_FALL: edge_det = ~stable & stable_d;
      default:   edge_det = stable ^ stable_d;
    endcase
  end

  assign wr_en = chipselect & ~write_n;
  assign clr   = (wr_en && address == ADDR_EDGE) ?
                 writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
      ADDR_RSVD:    rd_mux = '0;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGE:    rd_mux[WIDTH-1:0] = edgecapture;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable_d    <= RESET_LEVEL;
      edgecapture <= '0;
      irqmask     <= '0;
      readdata    <= '0;
    end else begin
      stable_d <= stable;
      // a set in the same cycle as a clear wins
      edgecapture <= (edgecapture & ~clr) | edge_det;
      if (wr_en && address == ADDR_IRQMASK)
        irqmask <= writedata[WIDTH-1:0];
      readdata <= rd_mux;
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_pio_in_debounce_irq.sv
// Scoreboarded bench: two PIO instances (falling and any-edge)
// sharing one Avalon bus, each with its own reset and inputs.
module tb_pio_in_debounce_irq;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        rst_b = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_a = 4'hF;
  logic [3:0]  in_b = 4'hF;
  logic [31:0] readdata_a, readdata_b;
  logic        irq_a, irq_b;

  always #5 clk = ~clk;

  pio_in_debounce_irq #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8),
    .EDGE_TYPE(1), .RESET_LEVEL(4'hF)
  ) u_dut_a (
    .clk(clk), .reset_n(rst_a), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_a),
    .readdata(readdata_a), .irq(irq_a)
  );

  pio_in_debounce_irq #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8),
    .EDGE_TYPE(2), .RESET_LEVEL(4'hF)
  ) u_dut_b (
    .clk(clk), .reset_n(rst_b), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_b),
    .readdata(readdata_b), .irq(irq_b)
  );

  typedef struct {
    string       tag;
    bit          dut;
    logic [31:0] exp;
  } rd_t;

  rd_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;
  bit  rd_vld = 1'b0;
  bit  rd_vld_q = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) rd_vld_q <= rd_vld;

  always @(negedge clk) begin
    rd_t e;
    if (rd_vld_q && sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, e.dut ? readdata_b : readdata_a, e.exp);
    end
  end

  task automatic rd(input bit dut, input logic [1:0] a,
                    input logic [31:0] exp, input string tag);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    sb.push_back('{tag, dut, exp});
    rd_vld = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; rd_vld = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d;
    chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n_data, n_irq, n_hi;

    idle(3);
    rst_a = 1'b1; rst_b = 1'b1;
    chk("rst_irq", {31'b0, irq_a}, 32'h0);
    rd(0, 2'd0, 32'hF, "rst_data");
    rd(0, 2'd1, 32'h0, "rst_rsvd");
    rd(0, 2'd2, 32'h0, "rst_mask");
    rd(0, 2'd3, 32'h0, "rst_edge");

    wr(2'd2, 32'h1);
    rd(0, 2'd2, 32'h1, "mask_1");
    chk("irq_idle", {31'b0, irq_a}, 32'h0);

    // falling edge on bit 0: latency through sync + filter + read
    @(negedge clk);
    address = 2'd0;
    in_a[0] = 1'b0;
    n_data = 0; n_irq = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (n_data == 0 && readdata_a[0] == 1'b0) n_data = k;
      if (n_irq == 0 && irq_a) n_irq = k;
    end
    chk("deb_data_lat", n_data, 32'd11);
    chk("deb_irq_lat", n_irq, 32'd11);
    rd(0, 2'd3, 32'h1, "deb_edge");
    rd(0, 2'd0, 32'hE, "deb_data");

    wr(2'd3, 32'h1);
    chk("clr_irq", {31'b0, irq_a}, 32'h0);
    rd(0, 2'd3, 32'h0, "clr_edge");

    // 7-cycle glitch must not survive an 8-cycle filter
    @(negedge clk);
    in_a[1] = 1'b0;
    idle(7);
    in_a[1] = 1'b1;
    n_hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (irq_a) n_hi++;
    end
    chk("glitch_irq", n_hi, 32'd0);
    rd(0, 2'd0, 32'hE, "glitch_data");
    rd(0, 2'd3, 32'h0, "glitch_edge");

    // clear of bit 1 lands on the same edge that sets it
    @(negedge clk);
    in_a[1] = 1'b0;
    idle(9);
    wr(2'd3, 32'h2);
    rd(0, 2'd3, 32'h2, "set_wins");
    chk("set_wins_irq", {31'b0, irq_a}, 32'h0);

    in_a[0] = 1'b1;
    idle(15);
    in_a[0] = 1'b0;
    idle(15);
    rd(0, 2'd3, 32'h3, "edge_3");
    wr(2'd2, 32'h0);
    chk("mask0_irq", {31'b0, irq_a}, 32'h0);
    wr(2'd2, 32'h2);
    chk("mask2_irq", {31'b0, irq_a}, 32'h1);
    rd(0, 2'd2, 32'h2, "mask_2");
    wr(2'd2, 32'hFFFF_FFFF);
    rd(0, 2'd2, 32'hF, "mask_hi0");
    wr(2'd1, 32'hFFFF_FFFF);
    rd(0, 2'd1, 32'h0, "rsvd_wr");
    rd(0, 2'd0, 32'hC, "data_c");

    // any-edge instance: press and release both capture
    @(negedge clk);
    in_b[2] = 1'b0;
    idle(15);
    rd(1, 2'd3, 32'h4, "b_press");
    rd(1, 2'd0, 32'hB, "b_data_b");
    wr(2'd3, 32'h4);
    rd(1, 2'd3, 32'h0, "b_clr");
    in_b[2] = 1'b1;
    idle(15);
    rd(1, 2'd3, 32'h4, "b_release");
    wr(2'd3, 32'h4);

    // reset mid-debounce, button released while in reset
    in_b[2] = 1'b0;
    idle(5);
    rst_b = 1'b0;
    in_b[2] = 1'b1;
    idle(2);
    rst_b = 1'b1;
    idle(20);
    rd(1, 2'd3, 32'h0, "b_rst_edge");
    rd(1, 2'd0, 32'hF, "b_rst_data");
    rd(1, 2'd2, 32'h0, "b_rst_mask");
    chk("b_rst_irq", {31'b0, irq_b}, 32'h0);

    idle(2);
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
